divider: RTL and testbench

Sequential signed 128-by-64-bit restoring divider; the inverse companion of the 64x64 Booth multiplier in the ALU datapath. It accepts a 128-bit two's-complement dividend and a 64-bit divisor, and produces a 64-bit quotient and remainder (truncating division). It uses the same op_start / op_clear / op_done handshake as the multiplier, so the ALU controller drives both blocks identically.

---
 rtl/divider.sv | 195 +++++++++++++++++++
 tb/tb_divider.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/divider.sv
// Sequential signed 128-by-64 restoring divider with truncating semantics.
// Shares the op_start / op_clear / op_done handshake with the Booth multiplier.

module cla_add #(
  parameter int W = 64
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum
);
  localparam int NG = W / 4;

  logic [W-1:0]  g;
  logic [W-1:0]  p;
  logic [W-1:0]  c;
  logic [NG-1:0] gc;

  // 4-bit lookahead groups; group carries chain from one group to the next.
  always_comb begin
    g     = a & b;
    p     = a ^ b;
    c     = '0;
    gc    = '0;
    gc[0] = cin;
    for (int k = 0; k < NG; k++) begin
      c[4*k]   = gc[k];
      c[4*k+1] = g[4*k] | (p[4*k] & gc[k]);
      c[4*k+2] = g[4*k+1] | (p[4*k+1] & g[4*k]) | ((&p[4*k +: 2]) & gc[k]);
      c[4*k+3] = g[4*k+2] | (p[4*k+2] & g[4*k+1]) | ((&p[4*k+1 +: 2]) & g[4*k])
               | ((&p[4*k +: 3]) & gc[k]);
      if (k < NG - 1)
        gc[k+1] = g[4*k+3] | (p[4*k+3] & g[4*k+2]) | ((&p[4*k+2 +: 2]) & g[4*k+1])
                | ((&p[4*k+1 +: 3]) & g[4*k]) | ((&p[4*k +: 4]) & gc[k]);
    end
    sum = p ^ c;
  end
endmodule

module divider (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         op_start,
  input  logic         op_clear,
  input  logic [127:0] dividend,
  input  logic [63:0]  divisor,
  output logic         op_done,
  output logic [63:0]  quotient,
  output logic [63:0]  remainder,
  output logic         div_by_zero,
  output logic         overflow
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t       state_q, state_d;
  logic [6:0]   cnt_q, cnt_d;
  logic [63:0]  prem_q, prem_d;   // partial remainder
  logic [63:0]  qsh_q, qsh_d;     // remaining dividend bits, refilled with quotient bits
  logic [63:0]  dvs_q, dvs_d;     // |divisor|
  logic         quo_sign_q, quo_sign_d;
  logic         rem_sign_q, rem_sign_d;
  logic         op_done_q, op_done_d;
  logic [63:0]  quotient_q, quotient_d;
  logic [63:0]  remainder_q, remainder_d;
  logic         div_by_zero_q, div_by_zero_d;
  logic         overflow_q, overflow_d;

  logic [127:0] dvd_neg, dvd_abs;
  logic [63:0]  dvs_neg, dvs_abs;
  logic [63:0]  quo_neg, rem_neg;
  logic [64:0]  shifted, diff;
  logic         fix_ovf;

  cla_add #(.W(128)) u_neg_dvd (.a(~dividend), .b('0), .cin(1'b1), .sum(dvd_neg));
  cla_add #(.W(64))  u_neg_dvs (.a(~divisor),  .b('0), .cin(1'b1), .sum(dvs_neg));
  cla_add #(.W(64))  u_neg_quo (.a(~qsh_q),    .b('0), .cin(1'b1), .sum(quo_neg));
  cla_add #(.W(64))  u_neg_rem (.a(~prem_q),   .b('0), .cin(1'b1), .sum(rem_neg));

  always_comb begin
    // NOTE: every _d starts from its _q so no path through the case can infer a latch.
    state_d       = state_q;
    cnt_d         = cnt_q;
    prem_d        = prem_q;
    qsh_d         = qsh_q;
    dvs_d         = dvs_q;
    quo_sign_d    = quo_sign_q;
    rem_sign_d    = rem_sign_q;
    op_done_d     = op_done_q;
    quotient_d    = quotient_q;
    remainder_d   = remainder_q;
    div_by_zero_d = div_by_zero_q;
    overflow_d    = overflow_q;

    dvd_abs = dividend[127] ? dvd_neg : dividend;
    dvs_abs = divisor[63] ? dvs_neg : divisor;
    shifted = {prem_q, qsh_q[63]};
    diff    = shifted - {1'b0, dvs_q};
    // A negative result may reach magnitude 2^63; a positive one may not.
    fix_ovf = quo_sign_q ? (qsh_q[63] & (|qsh_q[62:0])) : qsh_q[63];

    case (state_q)
      IDLE: begin
        if (op_start) begin
          quo_sign_d = dividend[127] ^ divisor[63];
          rem_sign_d = dividend[127];
          dvs_d      = dvs_abs;
          prem_d     = dvd_abs[127:64];
          qsh_d      = dvd_abs[63:0];
          cnt_d      = '0;
          if (divisor == '0) begin
            div_by_zero_d = 1'b1;
            op_done_d     = 1'b1;
            state_d       = DONE;
          end else if (dvd_abs[127:64] >= dvs_abs) begin
            overflow_d = 1'b1;
            op_done_d  = 1'b1;
            state_d    = DONE;
          end else begin
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        if (cnt_q == 7'd64) begin
          op_done_d = 1'b1;
          state_d   = DONE;
          if (fix_ovf) begin
            overflow_d = 1'b1;
          end else begin
            quotient_d  = quo_sign_q ? quo_neg : qsh_q;
            remainder_d = rem_sign_q ? rem_neg : prem_q;
          end
        end else begin
          // Partial remainder stays below |divisor|, so the restored value fits 64 bits.
          prem_d = diff[64] ? shifted[63:0] : diff[63:0];
          qsh_d  = {qsh_q[62:0], ~diff[64]};
          cnt_d  = cnt_q + 7'd1;
        end
      end
      default: ;
    endcase

    if (op_clear) begin
      state_d       = IDLE;
      cnt_d         = '0;
      prem_d        = '0;
      qsh_d         = '0;
      dvs_d         = '0;
      quo_sign_d    = 1'b0;
      rem_sign_d    = 1'b0;
      op_done_d     = 1'b0;
      quotient_d    = '0;
      remainder_d   = '0;
      div_by_zero_d = 1'b0;
      overflow_d    = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so all flops update together.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      prem_q        <= '0;
      qsh_q         <= '0;
      dvs_q         <= '0;
      quo_sign_q    <= 1'b0;
      rem_sign_q    <= 1'b0;
      op_done_q     <= 1'b0;
      quotient_q    <= '0;
      remainder_q   <= '0;
      div_by_zero_q <= 1'b0;
      overflow_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      prem_q        <= prem_d;
      qsh_q         <= qsh_d;
      dvs_q         <= dvs_d;
      quo_sign_q    <= quo_sign_d;
      rem_sign_q    <= rem_sign_d;
      op_done_q     <= op_done_d;
      quotient_q    <= quotient_d;
      remainder_q   <= remainder_d;
      div_by_zero_q <= div_by_zero_d;
      overflow_q    <= overflow_d;
    end
  end

  assign op_done     = op_done_q;
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = div_by_zero_q;
  assign overflow    = overflow_q;
endmodule

// File: tb/tb_divider.sv
// Directed bench for divider: signed results, exceptions, latency and handshake behaviour.

module tb_divider;
  logic         clk = 1'b0;
  logic         reset_n;
  logic         op_start;
  logic         op_clear;
  logic [127:0] dividend;
  logic [63:0]  divisor;
  logic         op_done;
  logic [63:0]  quotient;
  logic [63:0]  remainder;
  logic         div_by_zero;
  logic         overflow;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [127:0] dd;
    logic [63:0]  dv;
    logic [63:0]  q;
    logic [63:0]  r;
    logic         dbz;
    logic         ovf;
    int           lat;
  } vec_t;

  always #5 clk = ~clk;

  divider dut (
    .clk(clk), .reset_n(reset_n), .op_start(op_start), .op_clear(op_clear),
    .dividend(dividend), .divisor(divisor), .op_done(op_done),
    .quotient(quotient), .remainder(remainder),
    .div_by_zero(div_by_zero), .overflow(overflow)
  );

  task automatic start_op(input logic [127:0] dd, input logic [63:0] dv);
    @(negedge clk);
    dividend = dd;
    divisor  = dv;
    op_start = 1'b1;
    @(posedge clk);
    #1;
    op_start = 1'b0;
    dividend = ~dd;
    divisor  = ~dv;
  endtask

  // Counts edges after the start edge until op_done; optionally re-asserts op_start mid-run.
  task automatic wait_done(input int inject_at, output int lat);
    lat = -1;
    for (int i = 1; i <= 200; i++) begin
      if (i == inject_at) begin
        op_start = 1'b1;
        dividend = 128'd999;
        divisor  = 64'd3;
      end
      @(posedge clk);
      #1;
      op_start = 1'b0;
      if (op_done) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic pulse_clear();
    @(negedge clk);
    op_clear = 1'b1;
    @(posedge clk);
    #1;
    op_clear = 1'b0;
  endtask

  task automatic test_reset();
    reset_n  = 1'b0;
    op_start = 1'b0;
    op_clear = 1'b0;
    dividend = '0;
    divisor  = '0;
    #1;
    checks++;
    if ({op_done, div_by_zero, overflow, quotient, remainder} !== 131'd0) begin
      failures++;
      $display("FAIL reset_outputs: got %h expected 0", {op_done, div_by_zero, overflow, quotient, remainder});
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if ({op_done, div_by_zero, overflow, quotient, remainder} !== 131'd0) begin
      failures++;
      $display("FAIL idle_after_reset: got %h expected 0", {op_done, div_by_zero, overflow, quotient, remainder});
    end
  endtask

  task automatic test_arith();
    vec_t v[6];
    int   lat;
    v[0] = '{128'd100, 64'd7, 64'd14, 64'd2, 1'b0, 1'b0, 65};
    v[1] = '{-128'sd100, 64'd7, 64'hFFFF_FFFF_FFFF_FFF2, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0, 65};
    v[2] = '{128'd100, -64'sd7, 64'hFFFF_FFFF_FFFF_FFF2, 64'd2, 1'b0, 1'b0, 65};
    v[3] = '{128'hFFFF_FFFF_FFFF_FFFF_0000_0000_0000_0000, 64'd2,
             64'h8000_0000_0000_0000, 64'd0, 1'b0, 1'b0, 65};
    v[4] = '{128'h0000_0000_0000_0003_0000_0000_0000_0005, 64'h8000_0000_0000_0000,
             64'hFFFF_FFFF_FFFF_FFFA, 64'd5, 1'b0, 1'b0, 65};
    v[5] = '{-128'sd7, 64'd100, 64'd0, 64'hFFFF_FFFF_FFFF_FFF9, 1'b0, 1'b0, 65};
    for (int i = 0; i < 6; i++) begin
      pulse_clear();
      start_op(v[i].dd, v[i].dv);
      wait_done(0, lat);
      checks++;
      if (lat !== v[i].lat) begin
        failures++;
        $display("FAIL arith_latency[%0d]: got %0d expected %0d", i, lat, v[i].lat);
      end
      checks++;
      if ({op_done, div_by_zero, overflow, quotient, remainder} !== {1'b1, v[i].dbz, v[i].ovf, v[i].q, v[i].r}) begin
        failures++;
        $display("FAIL arith_result[%0d]: got %h expected %h", i,
                 {op_done, div_by_zero, overflow, quotient, remainder},
                 {1'b1, v[i].dbz, v[i].ovf, v[i].q, v[i].r});
      end
    end
  endtask

  task automatic test_exceptions();
    vec_t v[5];
    int   lat;
    v[0] = '{128'd12345, 64'd0, 64'd0, 64'd0, 1'b1, 1'b0, 1};
    v[1] = '{-128'sd5, 64'd0, 64'd0, 64'd0, 1'b1, 1'b0, 1};
    v[2] = '{128'h0000_0000_0000_0001_0000_0000_0000_0000, 64'd1, 64'd0, 64'd0, 1'b0, 1'b1, 1};
    v[3] = '{128'h0000_0000_0000_0001_0000_0000_0000_0000, 64'd2, 64'd0, 64'd0, 1'b0, 1'b1, 65};
    v[4] = '{128'h8000_0000_0000_0000_0000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
             64'd0, 64'd0, 1'b0, 1'b1, 1};
    for (int i = 0; i < 5; i++) begin
      pulse_clear();
      start_op(v[i].dd, v[i].dv);
      wait_done(0, lat);
      checks++;
      if (lat !== v[i].lat) begin
        failures++;
        $display("FAIL exc_latency[%0d]: got %0d expected %0d", i, lat, v[i].lat);
      end
      checks++;
      if ({op_done, div_by_zero, overflow, quotient, remainder} !== {1'b1, v[i].dbz, v[i].ovf, v[i].q, v[i].r}) begin
        failures++;
        $display("FAIL exc_result[%0d]: got %h expected %h", i,
                 {op_done, div_by_zero, overflow, quotient, remainder},
                 {1'b1, v[i].dbz, v[i].ovf, v[i].q, v[i].r});
      end
    end
  endtask

  task automatic test_busy_start();
    int lat;
    pulse_clear();
    start_op(128'd100, 64'd7);
    wait_done(10, lat);
    checks++;
    if (lat !== 65) begin
      failures++;
      $display("FAIL busy_start_latency: got %0d expected 65", lat);
    end
    checks++;
    if ({op_done, div_by_zero, overflow, quotient, remainder} !== {3'b100, 64'd14, 64'd2}) begin
      failures++;
      $display("FAIL busy_start_result: got %h expected %h",
               {op_done, div_by_zero, overflow, quotient, remainder}, {3'b100, 64'd14, 64'd2});
    end
  endtask

  task automatic test_done_start();
    @(negedge clk);
    dividend = 128'd50;
    divisor  = 64'd5;
    op_start = 1'b1;
    @(posedge clk);
    #1;
    op_start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({op_done, div_by_zero, overflow, quotient, remainder} !== {3'b100, 64'd14, 64'd2}) begin
      failures++;
      $display("FAIL done_start_hold: got %h expected %h",
               {op_done, div_by_zero, overflow, quotient, remainder}, {3'b100, 64'd14, 64'd2});
    end
    // Clear and start on the same edge: clear wins and the start is dropped.
    @(negedge clk);
    op_clear = 1'b1;
    op_start = 1'b1;
    dividend = 128'd50;
    divisor  = 64'd5;
    @(posedge clk);
    #1;
    op_clear = 1'b0;
    op_start = 1'b0;
    checks++;
    if ({op_done, div_by_zero, overflow, quotient, remainder} !== 131'd0) begin
      failures++;
      $display("FAIL clear_start_same_edge: got %h expected 0", {op_done, div_by_zero, overflow, quotient, remainder});
    end
    repeat (70) @(posedge clk);
    #1;
    checks++;
    if (op_done !== 1'b0) begin
      failures++;
      $display("FAIL clear_start_not_accepted: op_done got %b expected 0", op_done);
    end
  endtask

  task automatic test_clear_mid_busy();
    int lat;
    start_op(128'd100, 64'd7);
    repeat (29) @(posedge clk);
    pulse_clear();
    checks++;
    if ({op_done, div_by_zero, overflow, quotient, remainder} !== 131'd0) begin
      failures++;
      $display("FAIL clear_mid_busy: got %h expected 0", {op_done, div_by_zero, overflow, quotient, remainder});
    end
    repeat (40) @(posedge clk);
    #1;
    checks++;
    if (op_done !== 1'b0) begin
      failures++;
      $display("FAIL clear_mid_stays_idle: op_done got %b expected 0", op_done);
    end
    start_op(128'd1000, -64'sd3);
    wait_done(0, lat);
    checks++;
    if (lat !== 65 || {op_done, div_by_zero, overflow, quotient, remainder} !==
        {3'b100, 64'hFFFF_FFFF_FFFF_FEB3, 64'd1}) begin
      failures++;
      $display("FAIL clear_restart: lat %0d got %h expected lat 65 %h", lat,
               {op_done, div_by_zero, overflow, quotient, remainder},
               {3'b100, 64'hFFFF_FFFF_FFFF_FEB3, 64'd1});
    end
  endtask

  task automatic test_async_reset();
    int lat;
    // Reset while a result is held must clear it before any further edge.
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if ({op_done, div_by_zero, overflow, quotient, remainder} !== 131'd0) begin
      failures++;
      $display("FAIL async_reset_done: got %h expected 0", {op_done, div_by_zero, overflow, quotient, remainder});
    end
    @(negedge clk);
    reset_n = 1'b1;
    start_op(128'd100, 64'd7);
    repeat (20) @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    checks++;
    if ({op_done, div_by_zero, overflow, quotient, remainder} !== 131'd0) begin
      failures++;
      $display("FAIL async_reset_busy: got %h expected 0", {op_done, div_by_zero, overflow, quotient, remainder});
    end
    @(negedge clk);
    reset_n = 1'b1;
    repeat (70) @(posedge clk);
    #1;
    checks++;
    if (op_done !== 1'b0) begin
      failures++;
      $display("FAIL async_reset_aborted: op_done got %b expected 0", op_done);
    end
    start_op(128'd100, 64'd7);
    wait_done(0, lat);
    checks++;
    if (lat !== 65 || {op_done, div_by_zero, overflow, quotient, remainder} !== {3'b100, 64'd14, 64'd2}) begin
      failures++;
      $display("FAIL async_reset_restart: lat %0d got %h expected lat 65 %h", lat,
               {op_done, div_by_zero, overflow, quotient, remainder}, {3'b100, 64'd14, 64'd2});
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    // Clear at edge N, start at N+1.
    pulse_clear();
    start_op(-128'sd100, -64'sd7);
    wait_done(0, lat);
    checks++;
    if (lat !== 65 || {op_done, div_by_zero, overflow, quotient, remainder} !==
        {3'b100, 64'd14, 64'hFFFF_FFFF_FFFF_FFFE}) begin
      failures++;
      $display("FAIL back_to_back: lat %0d got %h expected lat 65 %h", lat,
               {op_done, div_by_zero, overflow, quotient, remainder},
               {3'b100, 64'd14, 64'hFFFF_FFFF_FFFF_FFFE});
    end
  endtask

  initial begin
    test_reset();
    test_arith();
    test_exceptions();
    test_busy_start();
    test_done_start();
    test_clear_mid_busy();
    test_async_reset();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
